// File: rtl/project_pkg.sv
// Shared matrix datapath types plus the result streamer's state encoding and sizing constants.
package project_pkg;

    localparam int unsigned MAT_MAX_ROWS           = 10;
    localparam int unsigned MAT_MAX_COLS           = 10;
    localparam int unsigned STREAM_IDX_W           = 4;
    localparam int unsigned DEFAULT_STREAM_TIMEOUT = 4096;

    typedef enum logic [2:0] {
        OP_ADD        = 3'd0,
        OP_SUB        = 3'd1,
        OP_MUL        = 3'd2,
        OP_SCALAR_MUL = 3'd3,
        OP_TRANSPOSE  = 3'd4,
        OP_CONV       = 3'd5
    } op_code_t;

    typedef logic signed [7:0] matrix_element_t;

    typedef struct packed {
        logic [STREAM_IDX_W-1:0]                               rows;
        logic [STREAM_IDX_W-1:0]                               cols;
        matrix_element_t [MAT_MAX_ROWS-1:0][MAT_MAX_COLS-1:0]  cells;
    } matrix_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_STREAM  = 3'd3,
        ST_RELEASE = 3'd4
    } streamer_state_t;

endpackage

// File: rtl/matrix_result_streamer.sv
// Runs one ALU operation via start/done, latches the result and streams it row-major over valid/ready.
// Optional ALU response timeout in LAUNCH: define MATRIX_STREAM_TIMEOUT_EN.
module matrix_result_streamer
    import project_pkg::*;
#(
    parameter int unsigned MAX_ROWS       = 10,
    parameter int unsigned MAX_COLS       = 10,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_STREAM_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  op_code_t                req_op,
    output logic                    alu_start,
    output op_code_t                alu_op,
    input  logic                    alu_done,
    input  matrix_t                 alu_result,
    input  logic                    alu_error,
    input  logic [31:0]             alu_cycle_cnt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output matrix_element_t         out_data,
    output logic [STREAM_IDX_W-1:0] out_row,
    output logic [STREAM_IDX_W-1:0] out_col,
    output logic                    out_eol,
    output logic                    out_last,
    output logic                    status_valid,
    output logic                    status_error,
    output logic [31:0]             status_cycles,
    output logic                    busy
);

    if (MAX_ROWS > MAT_MAX_ROWS || MAX_COLS > MAT_MAX_COLS || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("matrix_result_streamer: invalid configuration");
    end

    streamer_state_t         state_q, state_d;
    matrix_t                 mat_q, mat_d;
    op_code_t                alu_op_q, alu_op_d;
    logic                    alu_start_q, alu_start_d;
    logic                    out_valid_q, out_valid_d;
    matrix_element_t         out_data_q, out_data_d;
    logic [STREAM_IDX_W-1:0] out_row_q, out_row_d, out_col_q, out_col_d;
    logic                    out_eol_q, out_eol_d, out_last_q, out_last_d;
    logic                    status_valid_q, status_valid_d, status_error_q, status_error_d;
    logic [31:0]             status_cycles_q, status_cycles_d;

    logic [STREAM_IDX_W-1:0] rows_c, cols_c, nrow, ncol;
    logic                    req_fire, capture_abort, beat_fire, tmo_hit;

    assign req_ready     = (state_q == ST_IDLE) && !alu_done;
    assign busy          = (state_q != ST_IDLE);
    assign req_fire      = req_valid && req_ready;
    assign beat_fire     = out_valid_q && out_ready;
    assign rows_c        = (alu_result.rows > STREAM_IDX_W'(MAX_ROWS)) ? STREAM_IDX_W'(MAX_ROWS) : alu_result.rows;
    assign cols_c        = (alu_result.cols > STREAM_IDX_W'(MAX_COLS)) ? STREAM_IDX_W'(MAX_COLS) : alu_result.cols;
    assign capture_abort = alu_error || (rows_c == '0) || (cols_c == '0);

`ifdef MATRIX_STREAM_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;

    assign tmo_hit = (state_q == ST_LAUNCH) && !alu_done && (tmo_q == 32'(TIMEOUT_CYCLES - 1));
    assign tmo_d   = (state_q == ST_LAUNCH && !tmo_hit) ? tmo_q + 32'd1 : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Row-major successor of the beat currently on the port.
    always_comb begin
        if (out_col_q == mat_q.cols - 4'd1) begin
            ncol = '0;
            nrow = out_row_q + 4'd1;
        end else begin
            ncol = out_col_q + 4'd1;
            nrow = out_row_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            mat_q           <= '0;
            alu_op_q        <= OP_ADD;
            alu_start_q     <= 1'b0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_row_q       <= '0;
            out_col_q       <= '0;
            out_eol_q       <= 1'b0;
            out_last_q      <= 1'b0;
            status_valid_q  <= 1'b0;
            status_error_q  <= 1'b0;
            status_cycles_q <= '0;
        end else begin
            state_q         <= state_d;
            mat_q           <= mat_d;
            alu_op_q        <= alu_op_d;
            alu_start_q     <= alu_start_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            out_row_q       <= out_row_d;
            out_col_q       <= out_col_d;
            out_eol_q       <= out_eol_d;
            out_last_q      <= out_last_d;
            status_valid_q  <= status_valid_d;
            status_error_q  <= status_error_d;
            status_cycles_q <= status_cycles_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (req_fire) state_d = ST_LAUNCH;
            ST_LAUNCH:  if (alu_done) state_d = ST_CAPTURE;
                        else if (tmo_hit) state_d = ST_RELEASE;
            ST_CAPTURE: state_d = capture_abort ? ST_RELEASE : ST_STREAM;
            ST_STREAM:  if (beat_fire && out_last_q) state_d = ST_RELEASE;
            ST_RELEASE: if (!alu_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mat_d           = mat_q;
        alu_op_d        = alu_op_q;
        alu_start_d     = alu_start_q;
        out_valid_d     = out_valid_q;
        out_data_d      = out_data_q;
        out_row_d       = out_row_q;
        out_col_d       = out_col_q;
        out_eol_d       = out_eol_q;
        out_last_d      = out_last_q;
        status_valid_d  = 1'b0;
        status_error_d  = status_error_q;
        status_cycles_d = status_cycles_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    alu_op_d    = req_op;
                    alu_start_d = 1'b1;
                end
            end
            ST_LAUNCH: begin
                if (!alu_done && tmo_hit) begin
                    alu_start_d     = 1'b0;
                    status_valid_d  = 1'b1;
                    status_error_d  = 1'b1;
                    status_cycles_d = 32'(TIMEOUT_CYCLES);
                end
            end
            ST_CAPTURE: begin
                mat_d           = alu_result;
                mat_d.rows      = rows_c;
                mat_d.cols      = cols_c;
                alu_start_d     = 1'b0;
                status_error_d  = alu_error;
                status_cycles_d = alu_cycle_cnt;
                if (capture_abort) begin
                    status_valid_d = 1'b1;
                end else begin
                    // First beat comes straight from the ALU bus; later beats from the local copy.
                    out_valid_d = 1'b1;
                    out_data_d  = alu_result.cells[0][0];
                    out_row_d   = '0;
                    out_col_d   = '0;
                    out_eol_d   = (cols_c == 4'd1);
                    out_last_d  = (rows_c == 4'd1) && (cols_c == 4'd1);
                end
            end
            ST_STREAM: begin
                if (beat_fire) begin
                    if (out_last_q) begin
                        out_valid_d    = 1'b0;
                        status_valid_d = 1'b1;
                        status_error_d = 1'b0;
                    end else begin
                        out_row_d  = nrow;
                        out_col_d  = ncol;
                        out_data_d = mat_q.cells[nrow][ncol];
                        out_eol_d  = (ncol == mat_q.cols - 4'd1);
                        out_last_d = (nrow == mat_q.rows - 4'd1) && (ncol == mat_q.cols - 4'd1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign alu_start     = alu_start_q;
    assign alu_op        = alu_op_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_row       = out_row_q;
    assign out_col       = out_col_q;
    assign out_eol       = out_eol_q;
    assign out_last      = out_last_q;
    assign status_valid  = status_valid_q;
    assign status_error  = status_error_q;
    assign status_cycles = status_cycles_q;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed bench for matrix_result_streamer; timeout steps run only with MATRIX_STREAM_TIMEOUT_EN.
module tb_matrix_result_streamer;
    import project_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    op_code_t        req_op;
    logic            alu_start;
    op_code_t        alu_op;
    logic            alu_done;
    matrix_t         alu_result;
    logic            alu_error;
    logic [31:0]     alu_cycle_cnt;
    logic            out_valid;
    logic            out_ready;
    matrix_element_t out_data;
    logic [3:0]      out_row;
    logic [3:0]      out_col;
    logic            out_eol;
    logic            out_last;
    logic            status_valid;
    logic            status_error;
    logic [31:0]     status_cycles;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    matrix_result_streamer #(
        .MAX_ROWS       (10),
        .MAX_COLS       (10),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .alu_start     (alu_start),
        .alu_op        (alu_op),
        .alu_done      (alu_done),
        .alu_result    (alu_result),
        .alu_error     (alu_error),
        .alu_cycle_cnt (alu_cycle_cnt),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_row       (out_row),
        .out_col       (out_col),
        .out_eol       (out_eol),
        .out_last      (out_last),
        .status_valid  (status_valid),
        .status_error  (status_error),
        .status_cycles (status_cycles),
        .busy          (busy)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Variant 0: 1,2,3,... row-major over 3 columns; variant 1: conv-like values r*10+c-40.
    function automatic logic signed [7:0] cellval(input int variant, input int r, input int c);
        if (variant == 0) return 8'(r * 3 + c + 1);
        return 8'(r * 10 + c - 40);
    endfunction

    task automatic check_idle_outputs(input string pfx);
        chk({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({pfx, "_busy"}, 32'(busy), 32'd0);
        chk({pfx, "_alu_start"}, 32'(alu_start), 32'd0);
        chk({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({pfx, "_status_valid"}, 32'(status_valid), 32'd0);
        chk({pfx, "_out_data"}, 32'(out_data), 32'd0);
        chk({pfx, "_out_rc_eol_last"}, {24'd0, out_row, out_col} | 32'({out_eol, out_last}), 32'd0);
    endtask

    // Issue a request, let the ALU answer after 'delay' cycles, stop right after the CAPTURE edge.
    task automatic launch(input op_code_t op, input int rows, input int cols, input int variant,
                          input logic err, input int cyc, input int delay);
        alu_result = '0;
        alu_result.rows = 4'(rows);
        alu_result.cols = 4'(cols);
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                alu_result.cells[r][c] = cellval(variant, r, (variant == 0) ? c % 3 : c);
        req_op    = op;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("launch_start", 32'(alu_start), 32'd1);
        chk("launch_op", 32'(alu_op), 32'(op));
        chk("launch_req_ready", 32'(req_ready), 32'd0);
        repeat (delay - 1) tick();
        chk("launch_hold_start", 32'(alu_start), 32'd1);
        alu_done      = 1'b1;
        alu_error     = err;
        alu_cycle_cnt = 32'(cyc);
        tick();
        tick();
        chk("capture_start_low", 32'(alu_start), 32'd0);
    endtask

    // Drain beats; mode 0 = ready always high, mode 1 = ready pattern 1,0,0,1.
    task automatic stream(input int rows, input int cols, input int mode, input int variant, input int cyc);
        int beats = 0;
        int n = rows * cols;
        int k = 0;
        bit done = 0;
        bit stalled = 0;
        logic [7:0] held = '0;
        logic [3:0] pat = 4'b1001;
        while (!done && k < 400) begin
            out_ready = (mode == 0) ? 1'b1 : pat[3 - (k % 4)];
            if (stalled) chk("stall_hold", 32'(out_data), 32'(held));
            stalled = 0;
            if (out_valid) begin
                if (out_ready) begin
                    chk("beat_data", 32'(out_data), 32'(cellval(variant, beats / cols, beats % cols)));
                    chk("beat_row", 32'(out_row), 32'(beats / cols));
                    chk("beat_col", 32'(out_col), 32'(beats % cols));
                    chk("beat_eol", 32'(out_eol), 32'((beats % cols) == cols - 1));
                    chk("beat_last", 32'(out_last), 32'(beats == n - 1));
                    beats++;
                end else begin
                    held = out_data;
                    stalled = 1;
                end
            end
            if (status_valid) begin
                chk("done_beats", 32'(beats), 32'(n));
                chk("done_status_error", 32'(status_error), 32'd0);
                chk("done_status_cycles", status_cycles, 32'(cyc));
                chk("done_out_valid", 32'(out_valid), 32'd0);
                if (mode == 0) chk("back_to_back", 32'(k), 32'(n));
                done = 1;
            end
            tick();
            k++;
        end
        if (!done) chk("stream_timeout", 32'(k), 32'd0);
        out_ready = 1'b0;
        chk("status_one_cycle", 32'(status_valid), 32'd0);
    endtask

    task automatic release_alu();
        chk("release_req_ready", 32'(req_ready), 32'd0);
        chk("release_busy", 32'(busy), 32'd1);
        alu_done  = 1'b0;
        alu_error = 1'b0;
        tick();
        chk("back_idle_req_ready", 32'(req_ready), 32'd1);
        chk("back_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_op        = OP_ADD;
        alu_done      = 1'b0;
        alu_result    = '0;
        alu_error     = 1'b0;
        alu_cycle_cnt = '0;
        out_ready     = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Stale done in IDLE blocks new requests.
        alu_done  = 1'b1;
        req_valid = 1'b1;
        #1;
        chk("stale_done_req_ready", 32'(req_ready), 32'd0);
        tick();
        chk("stale_done_busy", 32'(busy), 32'd0);
        chk("stale_done_start", 32'(alu_start), 32'd0);
        alu_done  = 1'b0;
        req_valid = 1'b0;
        tick();
        chk("stale_cleared_req_ready", 32'(req_ready), 32'd1);

        // 2x3 add, ready held high.
        launch(OP_ADD, 2, 3, 0, 1'b0, 6, 6);
        stream(2, 3, 0, 0, 6);
        release_alu();

        // 2x3 with stalls.
        launch(OP_MUL, 2, 3, 0, 1'b0, 9, 2);
        stream(2, 3, 1, 0, 9);
        release_alu();

        // Dimension error: no beats.
        launch(OP_MUL, 2, 3, 0, 1'b1, 4, 3);
        chk("err_status_valid", 32'(status_valid), 32'd1);
        chk("err_status_error", 32'(status_error), 32'd1);
        chk("err_status_cycles", status_cycles, 32'd4);
        chk("err_out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("err_status_pulse", 32'(status_valid), 32'd0);
        chk("err_no_beat", 32'(out_valid), 32'd0);
        release_alu();

        // Zero-column result: completion without beats or error.
        launch(OP_TRANSPOSE, 3, 0, 0, 1'b0, 5, 1);
        chk("empty_status_valid", 32'(status_valid), 32'd1);
        chk("empty_status_error", 32'(status_error), 32'd0);
        chk("empty_out_valid", 32'(out_valid), 32'd0);
        tick();
        release_alu();

        // 8x10 conv.
        launch(OP_CONV, 8, 10, 1, 1'b0, 123, 3);
        stream(8, 10, 0, 1, 123);
        release_alu();

        // Oversized row count clamps to 10 rows of a single column.
        launch(OP_ADD, 15, 1, 0, 1'b0, 7, 2);
        stream(10, 1, 0, 0, 7);
        release_alu();

        // Reset during STREAM at beat 4.
        launch(OP_SUB, 2, 3, 0, 1'b0, 6, 2);
        out_ready = 1'b1;
        repeat (4) tick();
        chk("pre_reset_beat4", 32'(out_data), 32'd5);
        rst       = 1'b1;
        alu_done  = 1'b0;
        out_ready = 1'b0;
        tick();
        check_idle_outputs("midrst");
        chk("midrst_alu_op", 32'(alu_op), 32'd0);
        rst = 1'b0;
        tick();
        launch(OP_ADD, 2, 3, 0, 1'b0, 6, 6);
        stream(2, 3, 0, 0, 6);
        release_alu();

`ifdef MATRIX_STREAM_TIMEOUT_EN
        // ALU never answers.
        req_op    = OP_ADD;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 1; i < 16; i++) begin
            if (alu_start !== 1'b1) chk("tmo_start_held", 32'(alu_start), 32'd1);
            tick();
        end
        chk("tmo_start_held_end", 32'(alu_start), 32'd1);
        tick();
        chk("tmo_start_dropped", 32'(alu_start), 32'd0);
        chk("tmo_status_valid", 32'(status_valid), 32'd1);
        chk("tmo_status_error", 32'(status_error), 32'd1);
        chk("tmo_status_cycles", status_cycles, 32'd16);
        tick();
        chk("tmo_idle", 32'(req_ready), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
